uart_tx: RTL and testbench

//  - UART transmitter; the transmit-side counterpart of the UART_RX deserializer path.
//  - Accepts a parallel byte with a valid strobe and shifts out a frame on TX_OUT, LSB first.
//  - Frame = start(0), DATA_WIDTH data bits, optional parity bit, stop(1).
//  - CLK runs at the baud (bit) rate: exactly one frame bit per CLK cycle, no oversampling.

---
 rtl/uart_tx_pkg.sv | 16 +
 rtl/uart_tx_serializer.sv | 35 +++
 rtl/uart_tx.sv | 66 ++++++
 tb/tb_uart_tx.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: FSM state encoding, parity type constants and the default payload width.
package uart_tx_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD = 1'b1;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    START = 3'd1,
    DATA = 3'd2,
    PARITY = 3'd3,
    STOP = 3'd4
  } state_t;
  function automatic logic parity_bit(input logic ones_xor, input logic typ);
    return (typ == PAR_EVEN) ? ones_xor : ~ones_xor;
  endfunction
endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: holds the latched payload and the bit index that walks it LSB first.
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  shift_en_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  next_bit_o,
  output logic                  done_o
);
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  assign done_o = cnt_q == CW'(DATA_WIDTH - 1);
  assign data_o = data_q;
  // bit that goes on the line at the next edge while still shifting
  assign next_bit_o = data_q[cnt_q + 1'b1];
  always_comb begin
    data_d = load_i ? data_i : data_q;
    cnt_d = load_i ? '0 : shift_en_i ? (done_o ? '0 : cnt_q + 1'b1) : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data_q <= '0;
      cnt_q <= '0;
    end else begin
      data_q <= data_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: one-bit-per-clock UART transmitter with optional parity and back-to-back frames.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] p_data_i,
  input  logic                  data_valid_i,
  input  logic                  par_en_i,
  input  logic                  par_typ_i,
  output logic                  tx_o,
  output logic                  busy_o
);
  state_t state_q;
  logic tx_q, busy_q, par_en_q, par_typ_q;
  logic accept, next_bit, done;
  logic [DATA_WIDTH-1:0] data;
  assign accept = (state_q == IDLE || state_q == STOP) && data_valid_i;
  assign tx_o = tx_q;
  assign busy_o = busy_q;
  uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (accept),
    .data_i    (p_data_i),
    .shift_en_i(state_q == DATA),
    .data_o    (data),
    .next_bit_o(next_bit),
    .done_o    (done)
  );
  // outputs are loaded from the next state so the line changes on the accepting edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      tx_q <= 1'b1;
      busy_q <= 1'b0;
      par_en_q <= 1'b0;
      par_typ_q <= 1'b0;
    end else begin
      case (state_q)
        START: begin
          state_q <= DATA;
          tx_q <= data[0];
        end
        DATA: begin
          state_q <= done ? (par_en_q ? PARITY : STOP) : DATA;
          tx_q <= done ? (par_en_q ? parity_bit(^data, par_typ_q) : 1'b1) : next_bit;
        end
        PARITY: begin
          state_q <= STOP;
          tx_q <= 1'b1;
        end
        default: begin
          state_q <= accept ? START : IDLE;
          tx_q <= !accept;
          busy_q <= accept;
          if (accept) begin
            par_en_q <= par_en_i;
            par_typ_q <= par_typ_i;
          end
        end
      endcase
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed frame checks for uart_tx, sampled on the falling edge.
module tb_uart_tx;
  import uart_tx_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] p_data = 8'h00;
  logic data_valid = 1'b0;
  logic par_en = 1'b0;
  logic par_typ = 1'b0;
  logic tx, busy;
  int tests = 0;
  int fails = 0;

  uart_tx #(.DATA_WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .p_data_i    (p_data),
    .data_valid_i(data_valid),
    .par_en_i    (par_en),
    .par_typ_i   (par_typ),
    .tx_o        (tx),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic start_frame(input logic [7:0] d, input logic pe, input logic pt);
    @(negedge clk);
    p_data = d;
    par_en = pe;
    par_typ = pt;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    tests++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold tx=%b busy=%b expected tx=1 busy=0", tx, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
        fails++;
        $display("FAIL reset_idle%0d tx=%b busy=%b expected tx=1 busy=0", i, tx, busy);
      end
    end
  endtask

  task automatic test_no_parity;
    logic [9:0] exp = {1'b1, 8'hA5, 1'b0};
    start_frame(8'hA5, 1'b0, PAR_EVEN);
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (tx !== exp[i] || busy !== 1'b1) begin
        fails++;
        $display("FAIL nopar_bit%0d tx=%b busy=%b expected tx=%b busy=1", i, tx, busy, exp[i]);
      end
      @(negedge clk);
    end
    tests++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL nopar_end tx=%b busy=%b expected tx=1 busy=0", tx, busy);
    end
  endtask

  task automatic test_parity;
    logic [10:0] exps [2] = '{{1'b1, 1'b0, 8'hA5, 1'b0}, {1'b1, 1'b1, 8'hA5, 1'b0}};
    logic typs [2] = '{PAR_EVEN, PAR_ODD};
    for (int t = 0; t < 2; t++) begin
      start_frame(8'hA5, 1'b1, typs[t]);
      for (int i = 0; i < 11; i++) begin
        tests++;
        if (tx !== exps[t][i] || busy !== 1'b1) begin
          fails++;
          $display("FAIL par%0d_bit%0d tx=%b busy=%b expected tx=%b busy=1", t, i, tx, busy, exps[t][i]);
        end
        @(negedge clk);
      end
      tests++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
        fails++;
        $display("FAIL par%0d_end tx=%b busy=%b expected tx=1 busy=0", t, tx, busy);
      end
    end
  endtask

  task automatic test_latched;
    logic [10:0] exp = {1'b1, 1'b1, 8'h07, 1'b0};
    start_frame(8'h07, 1'b1, PAR_EVEN);
    for (int i = 0; i < 11; i++) begin
      if (i == 2) begin
        p_data = 8'hFF;
        par_typ = PAR_ODD;
        par_en = 1'b0;
      end
      tests++;
      if (tx !== exp[i] || busy !== 1'b1) begin
        fails++;
        $display("FAIL latched_bit%0d tx=%b busy=%b expected tx=%b busy=1", i, tx, busy, exp[i]);
      end
      @(negedge clk);
    end
    tests++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL latched_end tx=%b busy=%b expected tx=1 busy=0", tx, busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [19:0] exp = {1'b1, 8'hAA, 1'b0, 1'b1, 8'h55, 1'b0};
    start_frame(8'h55, 1'b0, PAR_EVEN);
    for (int i = 0; i < 20; i++) begin
      data_valid = (i == 3 || i == 9);
      p_data = (i == 3) ? 8'h0F : (i >= 9) ? 8'hAA : 8'h55;
      tests++;
      if (tx !== exp[i] || busy !== 1'b1) begin
        fails++;
        $display("FAIL b2b_bit%0d tx=%b busy=%b expected tx=%b busy=1", i, tx, busy, exp[i]);
      end
      @(negedge clk);
    end
    data_valid = 1'b0;
    tests++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_end tx=%b busy=%b expected tx=1 busy=0", tx, busy);
    end
  endtask

  task automatic test_reset_mid;
    logic [9:0] exp = {1'b1, 8'h3C, 1'b0};
    start_frame(8'h00, 1'b0, PAR_EVEN);
    repeat (5) @(negedge clk);
    tests++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL mid_pre tx=%b busy=%b expected tx=0 busy=1", tx, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_abort tx=%b busy=%b expected tx=1 busy=0", tx, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_idle tx=%b busy=%b expected tx=1 busy=0", tx, busy);
    end
    start_frame(8'h3C, 1'b0, PAR_EVEN);
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (tx !== exp[i] || busy !== 1'b1) begin
        fails++;
        $display("FAIL recover_bit%0d tx=%b busy=%b expected tx=%b busy=1", i, tx, busy, exp[i]);
      end
      @(negedge clk);
    end
    tests++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL recover_end tx=%b busy=%b expected tx=1 busy=0", tx, busy);
    end
  endtask

  initial begin
    test_reset;
    test_no_parity;
    test_parity;
    test_latched;
    test_back_to_back;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
